// File: rtl/mem_bank_array_model.sv
// mem_bank_array_model: NBANK x DEPTH x DW synchronous array responder with a bus protocol checker.
// Define FAULT_INJ_EN to add stuck-at read fault injection ports.
module mem_bank_array_model #(
    parameter int NBANK  = 64,
    parameter int DEPTH  = 1024,
    parameter int DW     = 8,
    parameter int RD_LAT = 1,
    localparam int BW    = $clog2(NBANK),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic [AW-1:0]    MEM_ADDR,
    input  logic             MEM_CE,
    input  logic             MEM_WEB,
    input  logic [NBANK-1:0] MEM_OEB,
    input  logic [NBANK-1:0] MEM_CSB,
    input  logic [DW-1:0]    MEM_IDATA,
    input  logic [BW-1:0]    MEM_ODATA_SELECT,
`ifdef FAULT_INJ_EN
    input  logic             FAULT_EN,
    input  logic [BW-1:0]    FAULT_BANK,
    input  logic [AW-1:0]    FAULT_ADDR,
    input  logic [DW-1:0]    FAULT_MASK,
    input  logic [DW-1:0]    FAULT_VAL,
`endif
    output logic [DW-1:0]    ODATA,
    output logic             ODATA_VLD,
    output logic             PROT_ERR
);

    logic [DW-1:0]     mem_q [NBANK][DEPTH];
    logic [BW-1:0]     bank;
    logic              csb_seen;
    logic              csb_multi;
    logic              accept;
    logic              wr_fire;
    logic              rd_fire;
    logic              oeb_orphan;
    logic [DW-1:0]     rd_word;
    logic [DW-1:0]     rd_data_q [RD_LAT];
    logic [DW-1:0]     rd_data_d [RD_LAT];
    logic [RD_LAT-1:0] rd_vld_q;
    logic [RD_LAT-1:0] rd_vld_d;
    logic              prot_err_q;
    logic              prot_err_d;

    // Bank decode: remember the low CSB bit and whether a second one was seen.
    always_comb begin
        bank      = '0;
        csb_seen  = 1'b0;
        csb_multi = 1'b0;
        for (int i = 0; i < NBANK; i++) begin
            if (!MEM_CSB[i]) begin
                csb_multi = csb_multi | csb_seen;
                csb_seen  = 1'b1;
                bank      = BW'(i);
            end
        end
    end

    assign accept     = MEM_CE && csb_seen && !csb_multi;
    assign wr_fire    = accept && !MEM_WEB;
    assign rd_fire    = accept && MEM_WEB && !MEM_OEB[bank];
    assign oeb_orphan = |(~MEM_OEB & MEM_CSB);

    // The stored word is never altered; faults only distort the value handed to the pipeline.
    always_comb begin
        rd_word = mem_q[bank][MEM_ADDR];
`ifdef FAULT_INJ_EN
        if (FAULT_EN && (bank == FAULT_BANK) && (MEM_ADDR == FAULT_ADDR)) begin
            rd_word = (rd_word & ~FAULT_MASK) | (FAULT_VAL & FAULT_MASK);
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (wr_fire) begin
            mem_q[bank][MEM_ADDR] <= MEM_IDATA;
        end
    end

    // Read pipeline: each stage loads only when valid data arrives, so the last stage holds ODATA.
    always_comb begin
        rd_vld_d[0]  = rd_fire;
        rd_data_d[0] = rd_fire ? rd_word : rd_data_q[0];
        for (int s = 1; s < RD_LAT; s++) begin
            rd_vld_d[s]  = rd_vld_q[s-1];
            rd_data_d[s] = rd_vld_q[s-1] ? rd_data_q[s-1] : rd_data_q[s];
        end
    end

    always_comb begin
        prot_err_d = prot_err_q;
        if (MEM_CE) begin
            if (csb_multi || oeb_orphan) begin
                prot_err_d = 1'b1;
            end
            if (accept && MEM_WEB && (MEM_ODATA_SELECT != bank)) begin
                prot_err_d = 1'b1;
            end
            if (wr_fire && !MEM_OEB[bank]) begin
                prot_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rd_vld_q   <= '0;
            prot_err_q <= 1'b0;
            for (int s = 0; s < RD_LAT; s++) begin
                rd_data_q[s] <= '0;
            end
        end else begin
            rd_vld_q   <= rd_vld_d;
            prot_err_q <= prot_err_d;
            for (int s = 0; s < RD_LAT; s++) begin
                rd_data_q[s] <= rd_data_d[s];
            end
        end
    end

    assign ODATA     = rd_data_q[RD_LAT-1];
    assign ODATA_VLD = rd_vld_q[RD_LAT-1];
    assign PROT_ERR  = prot_err_q;

endmodule

// File: tb/tb_mem_bank_array_model.sv
// Bench for mem_bank_array_model: two instances (RD_LAT=1 and RD_LAT=3) share one bus and are
// checked every cycle against a timestamped read-queue model, plus directed literal checks.
module tb_mem_bank_array_model;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  addr = '0;
    logic        ce = 1'b0;
    logic        web = 1'b1;
    logic [63:0] oeb = '1;
    logic [63:0] csb = '1;
    logic [7:0]  idata = '0;
    logic [5:0]  sel = '0;
`ifdef FAULT_INJ_EN
    logic        f_en = 1'b0;
    logic [5:0]  f_bank = '0;
    logic [9:0]  f_addr = '0;
    logic [7:0]  f_mask = '0;
    logic [7:0]  f_val = '0;
`endif
    logic [7:0]  od1, od3;
    logic        vld1, vld3, err1, err3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_bank_array_model #(.RD_LAT(1)) dut1 (
        .CLK(clk), .RSTN(rst_n), .MEM_ADDR(addr), .MEM_CE(ce), .MEM_WEB(web),
        .MEM_OEB(oeb), .MEM_CSB(csb), .MEM_IDATA(idata), .MEM_ODATA_SELECT(sel),
`ifdef FAULT_INJ_EN
        .FAULT_EN(f_en), .FAULT_BANK(f_bank), .FAULT_ADDR(f_addr),
        .FAULT_MASK(f_mask), .FAULT_VAL(f_val),
`endif
        .ODATA(od1), .ODATA_VLD(vld1), .PROT_ERR(err1)
    );

    mem_bank_array_model #(.RD_LAT(3)) dut3 (
        .CLK(clk), .RSTN(rst_n), .MEM_ADDR(addr), .MEM_CE(ce), .MEM_WEB(web),
        .MEM_OEB(oeb), .MEM_CSB(csb), .MEM_IDATA(idata), .MEM_ODATA_SELECT(sel),
`ifdef FAULT_INJ_EN
        .FAULT_EN(f_en), .FAULT_BANK(f_bank), .FAULT_ADDR(f_addr),
        .FAULT_MASK(f_mask), .FAULT_VAL(f_val),
`endif
        .ODATA(od3), .ODATA_VLD(vld3), .PROT_ERR(err3)
    );

    // Model: array contents, sticky error, and reads queued with the edge they become visible.
    typedef struct packed {
        int         due;
        logic [7:0] d;
    } rd_t;

    logic [7:0] m_mem [64][1024];
    rd_t        q1[$];
    rd_t        q3[$];
    int         edge_n = 0;
    logic       m_err = 1'b0;
    logic       e_vld1 = 1'b0, e_vld3 = 1'b0;
    logic [7:0] e_od1 = '0, e_od3 = '0;

    initial begin
        int         nlow;
        int         b;
        logic [7:0] w;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q1.delete(); q3.delete();
                m_err = 1'b0; e_vld1 = 1'b0; e_vld3 = 1'b0; e_od1 = '0; e_od3 = '0;
            end else begin
                edge_n++;
                nlow = $countones(~csb);
                b = 0;
                for (int i = 0; i < 64; i++) if (!csb[i]) b = i;
                if (ce) begin
                    if (nlow > 1) m_err = 1'b1;
                    if ((~oeb & csb) != 64'd0) m_err = 1'b1;
                    if (nlow == 1) begin
                        if (!web) begin
                            if (!oeb[b]) m_err = 1'b1;
                            m_mem[b][addr] = idata;
                        end else begin
                            if (int'(sel) != b) m_err = 1'b1;
                            if (!oeb[b]) begin
                                w = m_mem[b][addr];
`ifdef FAULT_INJ_EN
                                if (f_en && int'(f_bank) == b && f_addr == addr)
                                    w = (w & ~f_mask) | (f_val & f_mask);
`endif
                                q1.push_back('{due: edge_n,     d: w});
                                q3.push_back('{due: edge_n + 2, d: w});
                            end
                        end
                    end
                end
                e_vld1 = 1'b0;
                e_vld3 = 1'b0;
                if (q1.size() > 0 && q1[0].due == edge_n) begin
                    e_vld1 = 1'b1; e_od1 = q1[0].d; void'(q1.pop_front());
                end
                if (q3.size() > 0 && q3[0].due == edge_n) begin
                    e_vld3 = 1'b1; e_od3 = q3[0].d; void'(q3.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    // Capture of VLD pulses for the directed sequence checks.
    logic       cap_en = 1'b0;
    int         mon_cyc = 0;
    logic [7:0] cap1[$];
    logic [7:0] cap3[$];
    int         cyc1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] onehot_low(input int b);
        logic [63:0] v;
        v = '1;
        v[b] = 1'b0;
        return v;
    endfunction

    task automatic drive(input logic c, input logic w, input logic [63:0] cs, input logic [63:0] oe,
                         input logic [9:0] a, input logic [7:0] d, input logic [5:0] s);
        @(negedge clk);
        ce = c; web = w; csb = cs; oeb = oe; addr = a; idata = d; sel = s;
        @(posedge clk);
    endtask

    task automatic wr(input int b, input logic [9:0] a, input logic [7:0] d);
        logic [5:0] s;
        s = b[5:0];
        drive(1'b1, 1'b0, onehot_low(b), '1, a, d, s);
    endtask

    task automatic rd(input int b, input logic [9:0] a);
        logic [5:0] s;
        s = b[5:0];
        drive(1'b1, 1'b1, onehot_low(b), onehot_low(b), a, 8'h00, s);
    endtask

    task automatic idle();
        @(negedge clk);
        ce = 1'b0; web = 1'b1; csb = '1; oeb = '1;
    endtask

    task automatic rd_check(input int b, input logic [9:0] a, input logic [7:0] expv, input string name);
        rd(b, a);
        idle();
        check({name, "_vld_lat1"}, {31'd0, vld1}, 32'd1);
        check({name, "_data_lat1"}, {24'd0, od1}, {24'd0, expv});
        @(negedge clk);
        check({name, "_early_lat3"}, {31'd0, vld3}, 32'd0);
        @(negedge clk);
        check({name, "_vld_lat3"}, {31'd0, vld3}, 32'd1);
        check({name, "_data_lat3"}, {24'd0, od3}, {24'd0, expv});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ce = 1'b0; csb = '1; oeb = '1; web = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic stimulus();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset_odata", {24'd0, od1}, 32'd0);
        check("reset_vld", {30'd0, vld1, vld3}, 32'd0);
        check("reset_err", {30'd0, err1, err3}, 32'd0);

        // Single write then read.
        wr(3, 10'h010, 8'hA5);
        rd_check(3, 10'h010, 8'hA5, "t1");
        check("t1_err", {30'd0, err1, err3}, 32'd0);

        // Fill addr 0x3FF of every bank, then stream reads.
        for (int b = 0; b < 64; b++) wr(b, 10'h3FF, b[7:0]);
        cap1.delete(); cap3.delete(); cyc1.delete();
        cap_en = 1'b1;
        for (int b = 0; b < 64; b++) rd(b, 10'h3FF);
        idle();
        repeat (4) @(negedge clk);
        cap_en = 1'b0;
        check("t2_count_lat1", cap1.size(), 32'd64);
        check("t2_count_lat3", cap3.size(), 32'd64);
        if (cyc1.size() == 64) check("t2_consecutive", cyc1[63] - cyc1[0], 32'd63);
        for (int b = 0; b < 64 && b < cap1.size() && b < cap3.size(); b++) begin
            check("t2_data_lat1", {24'd0, cap1[b]}, b);
            check("t2_data_lat3", {24'd0, cap3[b]}, b);
        end
        check("t2_err", {30'd0, err1, err3}, 32'd0);

        // Write immediately followed by read of the same location.
        wr(9, 10'h0AA, 8'h3C);
        rd_check(9, 10'h0AA, 8'h3C, "raw");

        // Two CSB bits low: error, and the write is dropped.
        wr(1, 10'h020, 8'h11);
        wr(2, 10'h020, 8'h22);
        drive(1'b1, 1'b0, onehot_low(1) & onehot_low(2), '1, 10'h020, 8'hFF, 6'd1);
        idle();
        check("t3_err", {30'd0, err1, err3}, 32'd3);
        rd_check(1, 10'h020, 8'h11, "t3_bank1");
        rd_check(2, 10'h020, 8'h22, "t3_bank2");
        check("t3_err_sticky", {30'd0, err1, err3}, 32'd3);

        // Wrong output select: error flagged, data still returned.
        do_reset();
        check("t4_err_cleared", {30'd0, err1, err3}, 32'd0);
        wr(5, 10'h100, 8'h5C);
        drive(1'b1, 1'b1, onehot_low(5), onehot_low(5), 10'h100, 8'h00, 6'd6);
        idle();
        check("t4_sel_err", {31'd0, err1}, 32'd1);
        check("t4_sel_data", {24'd0, od1}, 32'h5C);
        repeat (3) @(negedge clk);
        // Output disabled: accepted but no VLD, ODATA holds.
        wr(5, 10'h101, 8'hE7);
        cap1.delete(); cap3.delete(); cyc1.delete();
        cap_en = 1'b1;
        drive(1'b1, 1'b1, onehot_low(5), '1, 10'h101, 8'h00, 6'd5);
        idle();
        repeat (3) @(negedge clk);
        cap_en = 1'b0;
        check("t4_oeb_novld", cap1.size() + cap3.size(), 32'd0);
        check("t4_oeb_hold", {24'd0, od3}, 32'h5C);

        // OEB low on a deselected bank, and a write with its own OEB low.
        do_reset();
        drive(1'b1, 1'b1, '1, onehot_low(4), 10'h000, 8'h00, 6'd4);
        idle();
        check("orphan_oeb_err", {31'd0, err1}, 32'd1);
        do_reset();
        drive(1'b1, 1'b0, onehot_low(6), onehot_low(6), 10'h030, 8'h77, 6'd6);
        idle();
        check("wr_oeb_err", {31'd0, err1}, 32'd1);
        check("wr_oeb_executes_err", {31'd0, err3}, 32'd1);
        rd_check(6, 10'h030, 8'h77, "wr_oeb_data");

        // Reset in flight drops the read.
        do_reset();
        cap1.delete(); cap3.delete(); cyc1.delete();
        cap_en = 1'b1;
        rd(3, 10'h010);
        #2 rst_n = 1'b0;
        @(negedge clk);
        ce = 1'b0; csb = '1; oeb = '1;
        check("t5_odata", {16'd0, od1, od3}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        cap_en = 1'b0;
        check("t5_no_vld", cap1.size() + cap3.size(), 32'd0);
        check("t5_odata_after", {16'd0, od1, od3}, 32'd0);

`ifdef FAULT_INJ_EN
        wr(7, 10'h055, 8'h00);
        f_en = 1'b1; f_bank = 6'd7; f_addr = 10'h055; f_mask = 8'h81; f_val = 8'h81;
        rd_check(7, 10'h055, 8'h81, "fault_on");
        f_en = 1'b0;
        rd_check(7, 10'h055, 8'h00, "fault_off");
`endif
        repeat (4) @(negedge clk);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                mon_cyc++;
                check("cyc_vld_lat1", {31'd0, vld1}, {31'd0, e_vld1});
                check("cyc_vld_lat3", {31'd0, vld3}, {31'd0, e_vld3});
                check("cyc_odata_lat1", {24'd0, od1}, {24'd0, e_od1});
                check("cyc_odata_lat3", {24'd0, od3}, {24'd0, e_od3});
                check("cyc_err", {30'd0, err1, err3}, {30'd0, m_err, m_err});
                if (cap_en && vld1) begin
                    cap1.push_back(od1);
                    cyc1.push_back(mon_cyc);
                end
                if (cap_en && vld3) cap3.push_back(od3);
            end
            stimulus();
        join_any
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
